// File: rtl/instruction_feeder.sv
// Instruction feeder: loadable program memory plus PC sequencer that drives the 19-bit
// jericalla instruction bus, inserting NOP bubbles for read-after-write hazards.
module instruction_feeder #(
  parameter int unsigned AW           = 5,
  parameter int unsigned HAZARD_DEPTH = 2,
  parameter logic [18:0] NOP_WORD     = 19'h0,
  parameter logic [15:0] WB_OP_MASK   = 16'hFFFE
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [18:0]   load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          halt_req,
  output logic [18:0]   instruction,
  output logic          instr_valid,
  output logic [AW:0]   pc,
  output logic          busy,
  output logic          done,
  output logic [15:0]   stall_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
  typedef struct packed {
    logic       wr;
    logic [4:0] rd;
  } hist_t;

  logic [18:0] mem [2**AW];

  state_e      state_q, state_d;
  hist_t       hist_q [HAZARD_DEPTH];
  hist_t       hist_d [HAZARD_DEPTH];
  logic [AW:0] len_q, len_d;
  logic [AW:0] pc_q, pc_d;
  logic [2:0]  drain_q, drain_d;
  logic [18:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] stall_q, stall_d;

  logic [18:0] cand;
  logic        hazard;
  logic        idle_like;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign cand      = mem[pc_q[AW-1:0]];

  // History entry for an issued word: only write-back opcodes leave a pending write.
  function automatic hist_t wb_entry(input logic [18:0] w);
    return {WB_OP_MASK[w[18:15]], w[14:10]};
  endfunction

  // NOTE: always_comb uses blocking assignments so later statements see earlier results.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZARD_DEPTH; i++) begin
      if (hist_q[i].wr && ((hist_q[i].rd == cand[9:5]) || (hist_q[i].rd == cand[4:0])))
        hazard = 1'b1;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default up front so no path leaves it unassigned (no latch).
    state_d = state_q;
    len_d   = len_q;
    pc_d    = pc_q;
    drain_d = drain_q;
    instr_d = NOP_WORD;
    valid_d = 1'b0;
    stall_d = stall_q;
    hist_d  = hist_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_d   = prog_len;
          pc_d    = '0;
          stall_d = '0;
          drain_d = '0;
          for (int i = 0; i < HAZARD_DEPTH; i++) hist_d[i] = '0;
          if (prog_len == '0) begin
            state_d = S_DRAIN;
          end else begin
            instr_d   = mem[0];
            valid_d   = 1'b1;
            pc_d      = (AW+1)'(1);
            hist_d[0] = wb_entry(mem[0]);
            state_d   = (prog_len == (AW+1)'(1)) ? S_DRAIN : S_RUN;
          end
        end
      end
      S_RUN: begin
        hist_d[0] = '0;
        for (int i = 1; i < HAZARD_DEPTH; i++) hist_d[i] = hist_q[i-1];
        if (halt_req) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else if (hazard) begin
          stall_d = (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1;
        end else begin
          instr_d   = cand;
          valid_d   = 1'b1;
          pc_d      = pc_q + (AW+1)'(1);
          hist_d[0] = wb_entry(cand);
          if (pc_q == len_q - (AW+1)'(1)) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end
      end
      S_DRAIN: begin
        hist_d[0] = '0;
        for (int i = 1; i < HAZARD_DEPTH; i++) hist_d[i] = hist_q[i-1];
        if (drain_q == 3'(HAZARD_DEPTH - 1)) state_d = S_DONE;
        else                                 drain_d = drain_q + 3'd1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      pc_q    <= '0;
      drain_q <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stall_q <= '0;
      for (int i = 0; i < HAZARD_DEPTH; i++) hist_q[i] <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      stall_q <= stall_d;
      hist_q  <= hist_d;
    end
  end

  // NOTE: program memory is deliberately not reset; a loaded program survives reset.
  always_ff @(posedge clk) begin
    if (load_we && idle_like) mem[load_addr] <= load_data;
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_instruction_feeder.sv
// Self-checking bench for instruction_feeder: directed programs plus randomized ones,
// compared edge by edge against an instruction-level issue model.
module tb_instruction_feeder;

  localparam int          AW   = 5;
  localparam int          HD   = 2;
  localparam logic [15:0] MASK = 16'hFFFE;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [18:0]   load_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          halt_req;
  logic [18:0]   instruction;
  logic          instr_valid;
  logic [AW:0]   pc;
  logic          busy;
  logic          done;
  logic [15:0]   stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [18:0] tb_mem [32];

  typedef struct {
    logic [18:0] instr;
    logic        valid;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   exp_pc;
  int   exp_stall;

  instruction_feeder #(
    .AW(AW), .HAZARD_DEPTH(HD), .NOP_WORD(19'h0), .WB_OP_MASK(MASK)
  ) dut (
    .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start), .halt_req(halt_req),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc), .busy(busy),
    .done(done), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  function automatic logic [18:0] mk(input int op, input int w, input int a, input int b);
    return {op[3:0], w[4:0], a[4:0], b[4:0]};
  endfunction

  // Register written by an issued word, or -1 when the opcode has no write-back.
  function automatic int dest_of(input logic [18:0] w);
    return MASK[w[18:15]] ? int'(w[14:10]) : -1;
  endfunction

  task automatic load_word(input int addr, input logic [18:0] data);
    tb_mem[addr] = data;
    load_we   = 1'b1;
    load_addr = AW'(addr);
    load_data = data;
    @(posedge clk); #1;
    load_we = 1'b0;
  endtask

  task automatic push_exp(input logic [18:0] i, input logic v, input logic b, input logic d);
    exp_t x;
    x.instr = i; x.valid = v; x.busy = b; x.done = d;
    exp_q.push_back(x);
  endtask

  // Expected bus activity, one entry per clock edge starting at the start edge.
  task automatic build_model(input int len, input int halt_at);
    int          hist[$];
    int          p;
    int          e;
    logic [18:0] w;
    bit          haz;
    exp_q.delete();
    exp_stall = 0;
    p = 0;
    if (len == 0) begin
      push_exp(19'h0, 1'b0, 1'b1, 1'b0);
    end else begin
      push_exp(tb_mem[0], 1'b1, 1'b1, 1'b0);
      hist.push_front(dest_of(tb_mem[0]));
      p = 1;
      e = 1;
      while (p < len) begin
        if (e == halt_at) begin
          push_exp(19'h0, 1'b0, 1'b1, 1'b0);
          break;
        end
        w   = tb_mem[p];
        haz = 1'b0;
        for (int k = 0; k < HD && k < hist.size(); k++)
          if (hist[k] >= 0 && (hist[k] == int'(w[9:5]) || hist[k] == int'(w[4:0]))) haz = 1'b1;
        if (haz) begin
          push_exp(19'h0, 1'b0, 1'b1, 1'b0);
          hist.push_front(-1);
          if (exp_stall < 65535) exp_stall++;
        end else begin
          push_exp(w, 1'b1, 1'b1, 1'b0);
          hist.push_front(dest_of(w));
          p++;
        end
        e++;
      end
    end
    for (int d = 0; d < HD; d++) push_exp(19'h0, 1'b0, d < HD - 1, d == HD - 1);
    exp_pc = p;
  endtask

  task automatic run_prog(input string tag, input int len, input int halt_at, input bit wr_busy);
    build_model(len, halt_at);
    prog_len = (AW+1)'(len);
    start    = 1'b1;
    for (int e = 0; e < exp_q.size(); e++) begin
      halt_req = (e == halt_at);
      if (wr_busy && e > 0) begin
        load_we   = 1'b1;
        load_addr = AW'(e % len);
        load_data = ~tb_mem[e % len];
      end
      @(posedge clk); #1;
      start    = 1'b0;
      halt_req = 1'b0;
      load_we  = 1'b0;
      check($sformatf("%s_e%0d_instr", tag, e), instruction, exp_q[e].instr);
      check($sformatf("%s_e%0d_valid", tag, e), instr_valid, exp_q[e].valid);
      check($sformatf("%s_e%0d_busy", tag, e), busy, exp_q[e].busy);
      check($sformatf("%s_e%0d_done", tag, e), done, exp_q[e].done);
    end
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_stall"}, stall_count, exp_stall);
  endtask

  initial begin
    int len;
    int halt_at;

    reset = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
    prog_len = '0; start = 1'b0; halt_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr", instruction, 19'h0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_stall", stall_count, 0);
    reset = 1'b0;

    // Three independent writers: back-to-back issue.
    load_word(0, mk(1, 2, 0, 0));
    load_word(1, mk(1, 3, 0, 0));
    load_word(2, mk(1, 4, 0, 0));
    run_prog("seq3", 3, -1, 1'b0);

    // Reader immediately after its producer: two bubbles.
    load_word(0, mk(1, 3, 1, 2));
    load_word(1, mk(2, 5, 3, 4));
    run_prog("raw1", 2, -1, 1'b0);

    // Dependency at distance two: one bubble.
    load_word(0, mk(1, 3, 1, 2));
    load_word(1, mk(1, 7, 8, 9));
    load_word(2, mk(1, 10, 3, 0));
    run_prog("raw2", 3, -1, 1'b0);

    // Opcode 0 carries no write-back, so its destination is not a hazard.
    load_word(0, mk(0, 3, 1, 2));
    load_word(1, mk(1, 5, 3, 3));
    run_prog("op0", 2, -1, 1'b0);

    // Halt on the third issue edge of an eight-word program.
    for (int i = 0; i < 8; i++) load_word(i, mk(1, 10 + i, 0, 1));
    run_prog("halt", 8, 2, 1'b0);
    check("halt_pc2", pc, 2);

    // Asynchronous reset in the middle of a run.
    prog_len = (AW+1)'(8);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    check("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_instr", instruction, 19'h0);
    check("mid_rst_valid", instr_valid, 1'b0);
    check("mid_rst_pc", pc, 0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    @(posedge clk); #1;
    check("held_rst_valid", instr_valid, 1'b0);
    reset = 1'b0;

    // Memory survives reset; writes during a run are ignored.
    load_word(0, mk(1, 2, 0, 0));
    load_word(1, mk(1, 3, 0, 0));
    load_word(2, mk(1, 4, 0, 0));
    run_prog("busywr", 3, -1, 1'b1);
    run_prog("rerun", 3, -1, 1'b0);

    run_prog("len0", 0, -1, 1'b0);
    run_prog("len1", 1, -1, 1'b0);

    // Randomized programs over a small register set to provoke hazards.
    for (int it = 0; it < 10; it++) begin
      len = int'($urandom_range(1, 20));
      for (int i = 0; i < len; i++)
        load_word(i, mk(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3))));
      halt_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len + 4)) : -1;
      run_prog($sformatf("rnd%0d", it), len, halt_at, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
